// File: rtl/maxi_burst_seq_if.sv
// maxi_burst_seq_if
//   AXI4 master-side bus bundle for the burst write/readback sequencer.
//   master modport: address/data/response channels as seen by the sequencer.
//   slave modport : same signals seen from the memory side.
//   No clock or reset inside; those stay plain ports on the modules.
interface maxi_burst_seq_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;

   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready,
      output araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready,
      input  araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/maxi_burst_seq.sv
// maxi_burst_seq
//   On a start pulse, writes one INCR burst of C_BURST_LEN beats
//   (C_DATA_SEED, C_DATA_SEED+1, ...) to C_BASE_ADDR, then reads the same
//   burst back and compares it against the written pattern.
// Ports
//   aclk_net     : sole clock, rising edge
//   aresetn_net  : asynchronous reset, ACTIVE HIGH despite the name
//   start        : one-cycle pulse, honoured only while idle
//   busy         : pass in progress
//   done         : one-cycle pulse at the end of a pass
//   error        : bad response, data mismatch or misplaced rlast (held)
//   err_cnt      : failing read beats, saturating at 255 (held)
//   m_axi        : AXI4 master bus (maxi_burst_seq_if.master)
//
// state | meaning
// IDLE  | waiting for start
// WADDR | presenting write address
// WDATA | streaming write beats
// WRESP | waiting for write response
// RADDR | presenting read address
// RDATA | receiving and checking read beats
// FIN   | done pulse, back to IDLE
module maxi_burst_seq #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 6,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter int                            C_BURST_LEN        = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 6'h0,
   parameter logic [31:0]                   C_DATA_SEED        = 32'h55
) (
   input  logic             aclk_net,
   input  logic             aresetn_net,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [7:0]       err_cnt,
   maxi_burst_seq_if.master m_axi
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WDATA = 3'd2,
      WRESP = 3'd3,
      RADDR = 3'd4,
      RDATA = 3'd5,
      FIN   = 3'd6
   } state_t;

   localparam logic [4:0] LAST_BEAT = 5'(C_BURST_LEN - 1);

   state_t                        state, state_nxt;
   logic [4:0]                    wbeat, rbeat;
   logic [C_M_AXI_DATA_WIDTH-1:0] rexp;

   assign rexp = C_DATA_SEED + 32'(rbeat);

   // address fields never change, so they are not part of the reset scheme
   assign m_axi.awaddr  = C_BASE_ADDR;
   assign m_axi.awlen   = 8'(C_BURST_LEN - 1);
   assign m_axi.awsize  = 3'b010;
   assign m_axi.awburst = 2'b01;
   assign m_axi.araddr  = C_BASE_ADDR;
   assign m_axi.arlen   = 8'(C_BURST_LEN - 1);
   assign m_axi.arsize  = 3'b010;
   assign m_axi.arburst = 2'b01;

   always_ff @(posedge aclk_net or posedge aresetn_net) begin
      if (aresetn_net) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start)                           state_nxt = WADDR;
         WADDR: if (m_axi.awready)                   state_nxt = WDATA;
         WDATA: if (m_axi.wready && wbeat == LAST_BEAT) state_nxt = WRESP;
         WRESP: if (m_axi.bvalid)                    state_nxt = RADDR;
         RADDR: if (m_axi.arready)                   state_nxt = RDATA;
         // leave on whichever comes first: rlast or the expected final beat
         RDATA: if (m_axi.rvalid && (m_axi.rlast || rbeat == LAST_BEAT))
                                                     state_nxt = FIN;
         FIN:                                        state_nxt = IDLE;
         default:                                    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_axi.awvalid = 1'b0;
      m_axi.wvalid  = 1'b0;
      m_axi.wdata   = '0;
      m_axi.wstrb   = '0;
      m_axi.wlast   = 1'b0;
      m_axi.bready  = 1'b0;
      m_axi.arvalid = 1'b0;
      m_axi.rready  = 1'b0;
      done          = 1'b0;
      busy          = (state != IDLE);
      case (state)
         WADDR: m_axi.awvalid = 1'b1;
         WDATA: begin
            m_axi.wvalid = 1'b1;
            m_axi.wdata  = C_DATA_SEED + 32'(wbeat);
            m_axi.wstrb  = '1;
            m_axi.wlast  = (wbeat == LAST_BEAT);
         end
         WRESP: m_axi.bready  = 1'b1;
         RADDR: m_axi.arvalid = 1'b1;
         RDATA: m_axi.rready  = 1'b1;
         FIN:   done          = 1'b1;
         default: ;
      endcase
   end

   // beat counters and sticky status; status clears only on an accepted start
   always_ff @(posedge aclk_net or posedge aresetn_net) begin
      if (aresetn_net) begin
         wbeat   <= '0;
         rbeat   <= '0;
         error   <= 1'b0;
         err_cnt <= '0;
      end else begin
         if (state == IDLE && start) begin
            wbeat   <= '0;
            rbeat   <= '0;
            error   <= 1'b0;
            err_cnt <= '0;
         end
         if (state == WDATA && m_axi.wready)
            wbeat <= wbeat + 5'd1;
         if (state == WRESP && m_axi.bvalid && m_axi.bresp != 2'b00)
            error <= 1'b1;
         if (state == RDATA && m_axi.rvalid) begin
            rbeat <= rbeat + 5'd1;
            if (m_axi.rdata != rexp || m_axi.rresp != 2'b00) begin
               error <= 1'b1;
               if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
            // rlast must coincide exactly with the final beat
            if (m_axi.rlast != (rbeat == LAST_BEAT))
               error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_maxi_burst_seq.sv
// Scoreboard bench for maxi_burst_seq: a responsive AXI slave, a monitor that
// checks every write beat / address / done pulse against queued expectations,
// and a stimulus process driving directed and random passes.
module tb_maxi_burst_seq;
   localparam int          LEN  = 4;
   localparam logic [31:0] SEED = 32'h55;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } wbeat_t;

   typedef struct {
      logic       err;
      logic [7:0] cnt;
   } res_t;

   logic       aclk_net = 1'b0;
   logic       aresetn_net = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, error;
   logic [7:0] err_cnt;

   maxi_burst_seq_if #(.ADDR_W(6), .DATA_W(32)) bus ();

   maxi_burst_seq #(
      .C_M_AXI_ADDR_WIDTH(6), .C_M_AXI_DATA_WIDTH(32), .C_BURST_LEN(LEN),
      .C_BASE_ADDR(6'h0), .C_DATA_SEED(SEED)
   ) dut (
      .aclk_net(aclk_net), .aresetn_net(aresetn_net), .start(start),
      .busy(busy), .done(done), .error(error), .err_cnt(err_cnt),
      .m_axi(bus)
   );

   always #5 aclk_net = ~aclk_net;

   int n_chk = 0;
   int n_err = 0;

   wbeat_t wq[$];
   res_t   resq[$];
   int     awq[$];
   int     w_acc = 0;

   // slave configuration for the current pass
   int          cfg_aw_hold = 1;
   int          cfg_ar_hold = 1;
   int          cfg_w_mode  = 0;   // 0 always ready, 1 toggle, 2 random
   logic [1:0]  cfg_bresp   = 2'b00;
   logic [15:0] cfg_rbad    = '0;
   logic [15:0] cfg_rresp   = '0;
   bit          cfg_r_stall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // ---------------- slave responder ----------------
   int aw_cyc, ar_cyc, rk;
   bit r_active;
   bit s_aw_hs, s_w_hs, s_wl, s_b_hs, s_ar_hs, s_r_hs;

   initial begin
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
      aw_cyc = 0; ar_cyc = 0; rk = 0; r_active = 0;
      forever begin
         @(negedge aclk_net);
         s_aw_hs = bus.awvalid && bus.awready;
         s_w_hs  = bus.wvalid && bus.wready;
         s_wl    = bus.wlast;
         s_b_hs  = bus.bvalid && bus.bready;
         s_ar_hs = bus.arvalid && bus.arready;
         s_r_hs  = bus.rvalid && bus.rready;
         @(posedge aclk_net);
         #1;
         if (aresetn_net) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
            bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
            aw_cyc = 0; ar_cyc = 0; rk = 0; r_active = 0;
         end else begin
            if (s_aw_hs) begin bus.awready = 0; aw_cyc = 0; end
            else if (bus.awvalid) begin aw_cyc++; bus.awready = (aw_cyc >= cfg_aw_hold); end

            case (cfg_w_mode)
               0:       bus.wready = 1'b1;
               1:       bus.wready = ~bus.wready;
               default: bus.wready = 1'($urandom_range(0, 1));
            endcase

            if (s_w_hs && s_wl) begin bus.bvalid = 1; bus.bresp = cfg_bresp; end
            if (s_b_hs) begin bus.bvalid = 0; bus.bresp = 0; end

            if (s_ar_hs) begin bus.arready = 0; ar_cyc = 0; rk = 0; r_active = 1; end
            else if (bus.arvalid) begin ar_cyc++; bus.arready = (ar_cyc >= cfg_ar_hold); end

            if (s_r_hs) begin
               rk++;
               if (rk == LEN) r_active = 0;
            end
            if (r_active && ((bus.rvalid && !s_r_hs) || !cfg_r_stall || $urandom_range(0, 3) != 0)) begin
               bus.rvalid = 1;
               bus.rdata  = cfg_rbad[rk] ? SEED + 32'(rk) + 32'd1 : SEED + 32'(rk);
               bus.rresp  = cfg_rresp[rk] ? 2'b10 : 2'b00;
               bus.rlast  = (rk == LEN - 1);
            end else begin
               bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int aw_seen = 0;

   initial begin
      forever begin
         @(negedge aclk_net);
         if (aresetn_net) begin
            aw_seen = 0;
         end else begin
            if (bus.awvalid) begin
               aw_seen++;
               if (bus.awready) begin
                  chk("awaddr", 32'(bus.awaddr), 32'h0);
                  chk("awlen", 32'(bus.awlen), LEN - 1);
                  chk("awsize", 32'(bus.awsize), 32'd2);
                  chk("awburst", 32'(bus.awburst), 32'd1);
                  chk("aw_ar_overlap", 32'(bus.arvalid), 32'd0);
                  if (awq.size() == 0) fail_now("unexpected_aw");
                  else chk("awvalid_hold", aw_seen, awq.pop_front());
                  aw_seen = 0;
               end
            end
            if (bus.arvalid && bus.arready) begin
               chk("araddr", 32'(bus.araddr), 32'h0);
               chk("arlen", 32'(bus.arlen), LEN - 1);
               chk("arsize", 32'(bus.arsize), 32'd2);
               chk("arburst", 32'(bus.arburst), 32'd1);
               chk("ar_aw_overlap", 32'(bus.awvalid), 32'd0);
            end
            if (bus.wvalid) begin
               if (wq.size() == 0) fail_now("unexpected_wbeat");
               else begin
                  chk("wdata", bus.wdata, wq[0].data);
                  chk("wlast", 32'(bus.wlast), 32'(wq[0].last));
                  chk("wstrb", 32'(bus.wstrb), 32'hF);
                  if (bus.wready) begin
                     void'(wq.pop_front());
                     w_acc++;
                  end
               end
            end
            if (bus.bvalid) chk("bready", 32'(bus.bready), 32'd1);
            if (bus.rvalid) chk("rready", 32'(bus.rready), 32'd1);
            if (done) begin
               if (resq.size() == 0) fail_now("unexpected_done");
               else begin
                  res_t r;
                  r = resq.pop_front();
                  chk("done_error", 32'(error), 32'(r.err));
                  chk("done_err_cnt", 32'(err_cnt), 32'(r.cnt));
                  chk("done_busy", 32'(busy), 32'd1);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_cfg(input int awh, input int arh, input int wm, input logic [1:0] br,
                          input logic [15:0] bad, input logic [15:0] rr, input bit stall);
      cfg_aw_hold = awh; cfg_ar_hold = arh; cfg_w_mode = wm; cfg_bresp = br;
      cfg_rbad = bad; cfg_rresp = rr; cfg_r_stall = stall;
   endtask

   // expectations follow directly from the pass configuration
   task automatic begin_pass();
      res_t r;
      r.cnt = 0;
      for (int k = 0; k < LEN; k++) begin
         wbeat_t b;
         b.data = SEED + 32'(k);
         b.last = (k == LEN - 1);
         wq.push_back(b);
         if (cfg_rbad[k] || cfg_rresp[k]) r.cnt++;
      end
      r.err = (cfg_bresp != 2'b00) || (r.cnt != 0);
      resq.push_back(r);
      awq.push_back(cfg_aw_hold);
      @(posedge aclk_net); #1 start = 1;
      @(posedge aclk_net); #1 start = 0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_awvalid", 32'(bus.awvalid), 32'd1);
      chk("start_error_clr", 32'(error), 32'd0);
      chk("start_errcnt_clr", 32'(err_cnt), 32'd0);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge aclk_net);
         if (done) seen = 1;
      end
      if (!seen) fail_now("timeout_done");
      @(posedge aclk_net); #1;
      chk("after_done_busy", 32'(busy), 32'd0);
      chk("after_done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int base;
      bit seen;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_awvalid", 32'(bus.awvalid), 32'd0);
      chk("rst_wvalid", 32'(bus.wvalid), 32'd0);
      chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
      chk("rst_awlen", 32'(bus.awlen), LEN - 1);
      @(negedge aclk_net); aresetn_net = 0;

      // clean pass, slave always ready
      set_cfg(1, 1, 0, 2'b00, 16'h0, 16'h0, 0);
      begin_pass(); wait_done();

      // AW held three cycles, WREADY toggling
      set_cfg(3, 1, 1, 2'b00, 16'h0, 16'h0, 0);
      begin_pass(); wait_done();

      // read beat 1 returns 0x57
      set_cfg(1, 1, 0, 2'b00, 16'h0002, 16'h0, 0);
      begin_pass(); wait_done();
      repeat (3) @(posedge aclk_net);
      #1;
      chk("held_error", 32'(error), 32'd1);
      chk("held_err_cnt", 32'(err_cnt), 32'd1);

      // start during WDATA must be ignored; the accepted start clears status
      set_cfg(1, 2, 1, 2'b00, 16'h0, 16'h0, 0);
      begin_pass();
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge aclk_net);
         if (bus.wvalid) seen = 1;
      end
      if (!seen) fail_now("timeout_wvalid");
      @(posedge aclk_net); #1 start = 1;
      @(posedge aclk_net); #1 start = 0;
      wait_done();

      // bad write response, read still runs
      set_cfg(2, 1, 0, 2'b10, 16'h0, 16'h0, 0);
      begin_pass(); wait_done();

      // reset while write beat 2 is on the bus
      set_cfg(1, 1, 0, 2'b00, 16'h0, 16'h0, 0);
      base = w_acc;
      begin_pass();
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge aclk_net); #2;
         if (w_acc >= base + 2) seen = 1;
      end
      if (!seen) fail_now("timeout_wbeat2");
      chk("pre_rst_wdata", bus.wdata, SEED + 32'd2);
      aresetn_net = 1;
      #1;
      chk("midrst_wvalid", 32'(bus.wvalid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      wq.delete(); resq.delete(); awq.delete();
      repeat (2) @(negedge aclk_net);
      aresetn_net = 0;
      begin_pass(); wait_done();

      // randomized passes
      for (int p = 0; p < 12; p++) begin
         logic [1:0] br;
         case ($urandom_range(0, 3))
            0: br = 2'b10;
            1: br = 2'b11;
            default: br = 2'b00;
         endcase
         set_cfg($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 2), br,
                 16'($urandom_range(0, 15)) & 16'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'h0,
                 1'($urandom_range(0, 1)));
         begin_pass(); wait_done();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
